run_ctrl: RTL and testbench
===========================

Name: run_ctrl

Overview:
- Synthesizable multi-core run controller that replaces ad-hoc bench logic for reset sequencing, trap detection, cycle timeout and pass/fail capture.
- Sits between the top level (or an FPGA host interface) and NUM_CORES instances of the core.
- Drives each core's active-low resetn, watches each core's trap and retire strobe, and captures each core's result register.
- Reports a single done/pass/timeout status.

Parameters:
- NUM_CORES, 1, number of monitored cores (1..16).
- CNT_W, 32, width of the cycle and retire counters.
- TIMEOUT, 5000, number of RUN cycles before timeout (1..2^CNT_W-1).
- RESET_CYCLES, 2, number of cycles core_resetn is held low after start (>=1).
- RES_W, 32, width of each core's result value.
- PASS_VALUE, 1, result value that counts as pass.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a run.
- core_resetn  out  NUM_CORES  active-low reset to each core.
- trap_i  in  NUM_CORES  trap level from each core.
- step_i  in  NUM_CORES  per-core retire pulse (core step_5 strobe).
- result_i  in  NUM_CORES*RES_W  per-core result register; core k occupies bits [k*RES_W +: RES_W].
- busy  out  1  high in HOLD or RUN.
- done  out  1  high in DONE.
- pass  out  1  valid when done=1.
- timed_out  out  1  valid when done=1.
- trapped  out  NUM_CORES  per-core trap-seen flags.
- fail_mask  out  NUM_CORES  per-core result != PASS_VALUE, valid for trapped cores.
- cycle_count  out  CNT_W  number of RUN cycles elapsed.
- retire_count  out  NUM_CORES*CNT_W  per-core retired instruction count.

Behaviour:
- Clock and reset: one clock domain (clk); reset is asynchronous and active-high.
- Reset values:
  - state=IDLE.
  - core_resetn all 0 (cores held in reset).
  - busy=0, done=0, pass=0, timed_out=0.
  - trapped=0, fail_mask=0, cycle_count=0, retire_count=0.
  - trap_q=all 1s.
- Reset asserted mid-run: immediate return to the reset values above, with no completion report.
- FSM: IDLE -> HOLD -> RUN -> DONE; start in DONE -> HOLD (re-run).
- IDLE:
  - start=1 -> HOLD.
  - On entry to HOLD, clear trapped, fail_mask, cycle_count, retire_count, pass and timed_out, and load the hold counter with RESET_CYCLES-1.
- HOLD:
  - core_resetn=0.
  - Counter decrements each cycle.
  - At counter 0 -> RUN.
  - Cores therefore see exactly RESET_CYCLES low cycles.
- RUN:
  - core_resetn all 1.
  - cycle_count increments every cycle.
  - start is ignored.
- Trap detection:
  - trap_q registers trap_i every cycle.
  - Core k traps in a cycle where state==RUN, trap_i[k]=1, trap_q[k]=0 and trapped[k]=0.
  - In that cycle: trapped[k]<=1, and fail_mask[k]<=(result_i[k]!=PASS_VALUE), sampled that same cycle.
  - A trap level already high on RUN entry is not a new trap; the core must drop trap and raise it again.
- Per-core hold-back after trap:
  - After core k traps, its core_resetn[k] returns to 0, so it is frozen.
  - Its retire_count stops.
- Retire counting: retire_count[k] increments on step_i[k] while state==RUN and trapped[k]=0, saturating at all 1s.
- Completion (evaluated on next-state values):
  - If all cores are trapped, go to DONE with timed_out=0 and pass=(fail_mask==0).
  - Otherwise, if cycle_count==TIMEOUT-1 in this cycle, go to DONE with timed_out=1 and pass=0.
  - Last trap and timeout in the same cycle: the trap wins (timed_out=0).
  - DONE is entered on the edge after the deciding cycle; done/pass/timed_out are registered.
- DONE:
  - core_resetn all 0.
  - cycle_count, retire_count, trapped and fail_mask hold.
  - start=1 -> HOLD.
- Width rules:
  - cycle_count never exceeds TIMEOUT-1.
  - TIMEOUT must fit in CNT_W (elaboration check).
  - Comparison with PASS_VALUE is over the full RES_W bits.

Decomposition:
- Package run_ctrl_pkg:
  - State enum run_state_t {IDLE, HOLD, RUN, DONE}, 2-bit.
  - Default parameter constants.
- One sub-module, run_ctrl_chan, instantiated NUM_CORES times. Per channel it holds:
  - trap_q edge detect,
  - trapped/fail flag,
  - saturating retire counter,
  - core_resetn gating.
- The top holds the FSM, hold counter, cycle counter and completion logic.

Test Plan:
- NUM_CORES=1, RESET_CYCLES=2: start at cycle 3 -> core_resetn low for exactly 2 cycles, then high; busy=1 from cycle 4.
- NUM_CORES=1, trap rises at RUN cycle 100 with result=1 and 100 step pulses -> done=1, pass=1, timed_out=0, cycle_count=100, retire_count=100, core_resetn=0.
- NUM_CORES=2: core0 traps at 40 with result 1, core1 traps at 70 with result 3 -> done after 70, pass=0, fail_mask=2'b10; core0 core_resetn low from cycle 41.
- TIMEOUT=50 with no trap -> done on the edge after cycle_count=49, timed_out=1, pass=0; trap held high from RUN entry also gives a timeout (no edge).
- TIMEOUT=50 with trap rising at cycle_count=49 -> timed_out=0, pass=1.
- Reset asserted mid-RUN at cycle 20 -> all outputs return to reset values asynchronously; a subsequent start in DONE re-runs with counters cleared.

Source files
------------

// File: rtl/run_ctrl_pkg.sv
// Shared types and default parameter values for the multi-core run controller.
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } run_state_t;

  localparam int unsigned DefNumCores   = 1;
  localparam int unsigned DefCntW       = 32;
  localparam int unsigned DefTimeout    = 5000;
  localparam int unsigned DefResetCycles = 2;
  localparam int unsigned DefResW       = 32;
  localparam int unsigned DefPassValue  = 1;

endpackage

// File: rtl/run_ctrl_chan.sv
// One monitored core: trap edge detect, trap/fail capture, retire counter and reset gating.
module run_ctrl_chan
  import run_ctrl_pkg::*;
#(
  parameter int unsigned            CNT_W      = DefCntW,
  parameter int unsigned            RES_W      = DefResW,
  parameter logic [RES_W-1:0]       PASS_VALUE = RES_W'(DefPassValue)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             run_i,
  input  logic             trap_i,
  input  logic             step_i,
  input  logic [RES_W-1:0] result_i,
  output logic             core_resetn_o,
  output logic             trapped_o,
  output logic             trapped_d_o,
  output logic             fail_o,
  output logic             fail_d_o,
  output logic [CNT_W-1:0] retire_o
);

  logic             trap_q;
  logic             trapped_q, trapped_d;
  logic             fail_q, fail_d;
  logic [CNT_W-1:0] retire_q, retire_d;
  logic             trap_evt;

  // A trap counts only on a rising edge seen while running and not yet trapped.
  assign trap_evt = run_i & trap_i & ~trap_q & ~trapped_q;

  always_comb begin
    trapped_d = trapped_q;
    fail_d    = fail_q;
    retire_d  = retire_q;
    if (clear_i) begin
      trapped_d = 1'b0;
      fail_d    = 1'b0;
      retire_d  = '0;
    end else begin
      if (trap_evt) begin
        trapped_d = 1'b1;
        fail_d    = (result_i != PASS_VALUE);
      end
      if (run_i && !trapped_q && step_i && (retire_q != '1)) begin
        retire_d = retire_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      trap_q    <= 1'b1;
      trapped_q <= 1'b0;
      fail_q    <= 1'b0;
      retire_q  <= '0;
    end else begin
      trap_q    <= trap_i;
      trapped_q <= trapped_d;
      fail_q    <= fail_d;
      retire_q  <= retire_d;
    end
  end

  assign core_resetn_o = run_i & ~trapped_q;
  assign trapped_o     = trapped_q;
  assign trapped_d_o   = trapped_d;
  assign fail_o        = fail_q;
  assign fail_d_o      = fail_d;
  assign retire_o      = retire_q;

endmodule

// File: rtl/run_ctrl.sv
// Run controller: sequences core resets, watches traps and timeout, reports pass/fail.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int unsigned      NUM_CORES    = DefNumCores,
  parameter int unsigned      CNT_W        = DefCntW,
  parameter int unsigned      TIMEOUT      = DefTimeout,
  parameter int unsigned      RESET_CYCLES = DefResetCycles,
  parameter int unsigned      RES_W        = DefResW,
  parameter logic [RES_W-1:0] PASS_VALUE   = RES_W'(DefPassValue)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  output logic [NUM_CORES-1:0]       core_resetn,
  input  logic [NUM_CORES-1:0]       trap_i,
  input  logic [NUM_CORES-1:0]       step_i,
  input  logic [NUM_CORES*RES_W-1:0] result_i,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic                       timed_out,
  output logic [NUM_CORES-1:0]       trapped,
  output logic [NUM_CORES-1:0]       fail_mask,
  output logic [CNT_W-1:0]           cycle_count,
  output logic [NUM_CORES*CNT_W-1:0] retire_count
);

  localparam int unsigned HoldW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  if (NUM_CORES < 1 || NUM_CORES > 16) begin : g_bad_cores
    $error("run_ctrl: NUM_CORES out of range");
  end
  if (RESET_CYCLES < 1) begin : g_bad_reset_cycles
    $error("run_ctrl: RESET_CYCLES must be at least 1");
  end
  if (TIMEOUT < 1 || 64'(TIMEOUT) > ((64'd1 << CNT_W) - 64'd1)) begin : g_bad_timeout
    $error("run_ctrl: TIMEOUT does not fit in CNT_W");
  end

  run_state_t       state_q, state_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic             pass_q, pass_d;
  logic             to_q, to_d;
  logic             clear;
  logic             run;

  logic [NUM_CORES-1:0] trapped_d_w;
  logic [NUM_CORES-1:0] fail_d_w;

  assign run = (state_q == RUN);

  for (genvar k = 0; k < NUM_CORES; k++) begin : g_chan
    run_ctrl_chan #(
      .CNT_W      (CNT_W),
      .RES_W      (RES_W),
      .PASS_VALUE (PASS_VALUE)
    ) u_chan (
      .clk_i         (clk),
      .rst_i         (reset),
      .clear_i       (clear),
      .run_i         (run),
      .trap_i        (trap_i[k]),
      .step_i        (step_i[k]),
      .result_i      (result_i[k*RES_W +: RES_W]),
      .core_resetn_o (core_resetn[k]),
      .trapped_o     (trapped[k]),
      .trapped_d_o   (trapped_d_w[k]),
      .fail_o        (fail_mask[k]),
      .fail_d_o      (fail_d_w[k]),
      .retire_o      (retire_count[k*CNT_W +: CNT_W])
    );
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cycle_d = cycle_q;
    pass_d  = pass_q;
    to_d    = to_q;
    clear   = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = HOLD;
          hold_d  = HoldW'(RESET_CYCLES - 1);
          cycle_d = '0;
          pass_d  = 1'b0;
          to_d    = 1'b0;
          clear   = 1'b1;
        end
      end
      HOLD: begin
        if (hold_q == '0) begin
          state_d = RUN;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      RUN: begin
        // Completion uses next-state trap flags so a last trap beats a same-cycle timeout.
        if (&trapped_d_w) begin
          state_d = DONE;
          to_d    = 1'b0;
          pass_d  = ~|fail_d_w;
        end else if (cycle_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = DONE;
          to_d    = 1'b1;
          pass_d  = 1'b0;
        end else begin
          cycle_d = cycle_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
      cycle_q <= '0;
      pass_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cycle_q <= cycle_d;
      pass_q  <= pass_d;
      to_q    <= to_d;
    end
  end

  assign busy        = (state_q == HOLD) || (state_q == RUN);
  assign done        = (state_q == DONE);
  assign pass        = pass_q;
  assign timed_out   = to_q;
  assign cycle_count = cycle_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl: three instances (1 core, 2 cores, 1 core with short timeout).
module tb_run_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Single core, default timeout.
  logic        s_start, s_trap, s_step;
  logic [31:0] s_res;
  logic        s_rstn, s_busy, s_done, s_pass, s_to, s_trapped, s_fail;
  logic [31:0] s_cyc, s_ret;

  // Two cores.
  logic        m_start;
  logic [1:0]  m_trap, m_step;
  logic [63:0] m_res;
  logic [1:0]  m_rstn, m_trapped, m_fail;
  logic        m_busy, m_done, m_pass, m_to;
  logic [31:0] m_cyc;
  logic [63:0] m_ret;

  // Single core, TIMEOUT=50, RESET_CYCLES=3.
  logic        t_start, t_trap, t_step;
  logic [31:0] t_res;
  logic        t_rstn, t_busy, t_done, t_pass, t_to, t_trapped, t_fail;
  logic [31:0] t_cyc, t_ret;

  run_ctrl #(.NUM_CORES(1)) u_s (
    .clk (clk), .reset (reset), .start (s_start), .core_resetn (s_rstn),
    .trap_i (s_trap), .step_i (s_step), .result_i (s_res), .busy (s_busy), .done (s_done),
    .pass (s_pass), .timed_out (s_to), .trapped (s_trapped), .fail_mask (s_fail),
    .cycle_count (s_cyc), .retire_count (s_ret)
  );

  run_ctrl #(.NUM_CORES(2)) u_m (
    .clk (clk), .reset (reset), .start (m_start), .core_resetn (m_rstn),
    .trap_i (m_trap), .step_i (m_step), .result_i (m_res), .busy (m_busy), .done (m_done),
    .pass (m_pass), .timed_out (m_to), .trapped (m_trapped), .fail_mask (m_fail),
    .cycle_count (m_cyc), .retire_count (m_ret)
  );

  run_ctrl #(.NUM_CORES(1), .TIMEOUT(50), .RESET_CYCLES(3)) u_t (
    .clk (clk), .reset (reset), .start (t_start), .core_resetn (t_rstn),
    .trap_i (t_trap), .step_i (t_step), .result_i (t_res), .busy (t_busy), .done (t_done),
    .pass (t_pass), .timed_out (t_to), .trapped (t_trapped), .fail_mask (t_fail),
    .cycle_count (t_cyc), .retire_count (t_ret)
  );

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    s_start = 0; s_trap = 0; s_step = 0; s_res = 0;
    m_start = 0; m_trap = 0; m_step = 0; m_res = 0;
    t_start = 0; t_trap = 0; t_step = 0; t_res = 0;
    tick(2);

    // Reset values.
    chk("rst_rstn", 64'(s_rstn), 64'd0);
    chk("rst_busy", 64'(s_busy), 64'd0);
    chk("rst_done", 64'(s_done), 64'd0);
    chk("rst_pass", 64'(s_pass), 64'd0);
    chk("rst_to", 64'(s_to), 64'd0);
    chk("rst_trapped", 64'(m_trapped), 64'd0);
    chk("rst_fail", 64'(m_fail), 64'd0);
    chk("rst_cyc", 64'(s_cyc), 64'd0);
    chk("rst_ret", m_ret, 64'd0);
    reset = 1'b0;
    tick();

    // Reset sequencing: two low cycles in HOLD, then release.
    s_start = 1;
    tick();
    s_start = 0;
    chk("hold1_busy", 64'(s_busy), 64'd1);
    chk("hold1_rstn", 64'(s_rstn), 64'd0);
    tick();
    chk("hold2_rstn", 64'(s_rstn), 64'd0);
    tick();
    chk("run_rstn", 64'(s_rstn), 64'd1);
    chk("run_cyc0", 64'(s_cyc), 64'd0);

    // 100 retires, trap at cycle 100 with passing result.
    s_step = 1;
    tick(100);
    s_step = 0;
    chk("s_cyc100", 64'(s_cyc), 64'd100);
    chk("s_ret100", 64'(s_ret), 64'd100);
    chk("s_notdone", 64'(s_done), 64'd0);
    s_trap = 1; s_res = 32'd1;
    tick();
    chk("s_done", 64'(s_done), 64'd1);
    chk("s_pass", 64'(s_pass), 64'd1);
    chk("s_to", 64'(s_to), 64'd0);
    chk("s_cyc_hold", 64'(s_cyc), 64'd100);
    chk("s_ret_hold", 64'(s_ret), 64'd100);
    chk("s_rstn_done", 64'(s_rstn), 64'd0);
    chk("s_busy_done", 64'(s_busy), 64'd0);
    s_trap = 0;

    // Two cores: core0 passes at 40, core1 fails at 70.
    m_start = 1;
    tick();
    m_start = 0;
    tick(2);
    chk("m_rstn_run", 64'(m_rstn), 64'd3);
    tick(40);
    m_trap = 2'b01; m_res = {32'd3, 32'd1};
    tick();
    chk("m_trapped0", 64'(m_trapped), 64'd1);
    chk("m_rstn_frozen", 64'(m_rstn), 64'd2);
    chk("m_fail0", 64'(m_fail), 64'd0);
    chk("m_notdone", 64'(m_done), 64'd0);
    m_step = 2'b11;
    tick();
    m_step = 2'b00;
    chk("m_ret_freeze", m_ret, {32'd1, 32'd0});
    tick(28);
    chk("m_cyc70", 64'(m_cyc), 64'd70);
    m_trap = 2'b11;
    tick();
    chk("m_done", 64'(m_done), 64'd1);
    chk("m_pass", 64'(m_pass), 64'd0);
    chk("m_to", 64'(m_to), 64'd0);
    chk("m_failmask", 64'(m_fail), 64'd2);
    chk("m_cyc", 64'(m_cyc), 64'd70);
    chk("m_rstn_done", 64'(m_rstn), 64'd0);
    m_trap = 2'b00;

    // Timeout with no trap; three-cycle reset hold.
    t_start = 1;
    tick();
    t_start = 0;
    tick(2);
    chk("t_hold3_rstn", 64'(t_rstn), 64'd0);
    tick();
    chk("t_run_rstn", 64'(t_rstn), 64'd1);
    tick(49);
    chk("t_cyc49", 64'(t_cyc), 64'd49);
    chk("t_notdone", 64'(t_done), 64'd0);
    tick();
    chk("t_done", 64'(t_done), 64'd1);
    chk("t_to", 64'(t_to), 64'd1);
    chk("t_pass", 64'(t_pass), 64'd0);
    chk("t_cyc_cap", 64'(t_cyc), 64'd49);

    // Trap held high from RUN entry is not a trap.
    t_trap = 1; t_res = 32'd1; t_start = 1;
    tick();
    t_start = 0;
    tick(3);
    chk("t2_cyc0", 64'(t_cyc), 64'd0);
    tick(50);
    chk("t2_done", 64'(t_done), 64'd1);
    chk("t2_to", 64'(t_to), 64'd1);
    chk("t2_trapped", 64'(t_trapped), 64'd0);

    // Trap rising on the timeout cycle wins.
    t_trap = 0; t_start = 1;
    tick();
    t_start = 0;
    tick(3);
    tick(49);
    t_trap = 1;
    tick();
    chk("t3_done", 64'(t_done), 64'd1);
    chk("t3_to", 64'(t_to), 64'd0);
    chk("t3_pass", 64'(t_pass), 64'd1);
    chk("t3_cyc", 64'(t_cyc), 64'd49);
    t_trap = 0;

    // Asynchronous reset mid-RUN.
    s_start = 1;
    tick();
    s_start = 0;
    tick(2);
    s_step = 1;
    tick(20);
    chk("r_busy", 64'(s_busy), 64'd1);
    chk("r_ret20", 64'(s_ret), 64'd20);
    s_step = 0;
    #2 reset = 1'b1;
    #1;
    chk("r_busy0", 64'(s_busy), 64'd0);
    chk("r_rstn0", 64'(s_rstn), 64'd0);
    chk("r_cyc0", 64'(s_cyc), 64'd0);
    chk("r_ret0", 64'(s_ret), 64'd0);
    chk("r_done0", 64'(s_done), 64'd0);
    #1 reset = 1'b0;
    tick();

    // Run to a failing completion, then re-run from DONE.
    s_start = 1;
    tick();
    s_start = 0;
    tick(2);
    tick(5);
    s_trap = 1; s_res = 32'd2;
    tick();
    chk("f_done", 64'(s_done), 64'd1);
    chk("f_pass", 64'(s_pass), 64'd0);
    chk("f_fail", 64'(s_fail), 64'd1);
    chk("f_cyc", 64'(s_cyc), 64'd5);
    s_trap = 0; s_start = 1;
    tick();
    s_start = 0;
    chk("rr_busy", 64'(s_busy), 64'd1);
    chk("rr_done", 64'(s_done), 64'd0);
    chk("rr_cyc", 64'(s_cyc), 64'd0);
    chk("rr_trapped", 64'(s_trapped), 64'd0);
    chk("rr_fail", 64'(s_fail), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
